// File: rtl/rob_multiport.sv
// ---------------------------------------------------------------------------
// rob_multiport
//   Parametrised reorder buffer. Allocates up to DISPATCH_W entries per cycle
//   in program order. Accepts up to COMPLETE_W out-of-order completions per
//   cycle. Retires up to RETIRE_W consecutive completed entries per cycle.
//   It also answers per-tag readiness and data lookups for two source
//   operands, and supports a single-cycle flush.
//
//   Optional feature: define ROB_CMP_BYPASS_EN so that the lookup also sees
//   completions arriving in the current cycle. Without it, a completion
//   becomes visible to the lookup one cycle later.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   flush           discard every entry (overrides dispatch/complete/retire)
//   disp_*          per-lane allocate request (valid, pc, areg, tag), lane 0
//                   in the LSBs
//   disp_ready      all lanes can be accepted this cycle
//   disp_idx        entry index assigned to each lane
//   cmp_*           completion ports (valid, entry index, result data)
//   src_tag         two tags to look up
//   src_ready/data  lookup result; data is 0 unless ready
//   ret_*           retire lanes (valid, areg, tag, data, pc)
//   count/full/empty occupancy
// ---------------------------------------------------------------------------
module rob_multiport #(
    parameter int ROB_DEPTH  = 64,
    parameter int DISPATCH_W = 2,
    parameter int COMPLETE_W = 3,
    parameter int RETIRE_W   = 2,
    parameter int XLEN       = 32,
    parameter int AREG_W     = 5,
    parameter int TAG_W      = 6,
    parameter int PC_W       = 32,
    localparam int IW        = $clog2(ROB_DEPTH),
    localparam int CW        = IW + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,

    input  logic [DISPATCH_W-1:0]        disp_valid,
    input  logic [DISPATCH_W*PC_W-1:0]   disp_pc,
    input  logic [DISPATCH_W*AREG_W-1:0] disp_areg,
    input  logic [DISPATCH_W*TAG_W-1:0]  disp_tag,
    output logic                         disp_ready,
    output logic [DISPATCH_W*IW-1:0]     disp_idx,

    input  logic [COMPLETE_W-1:0]        cmp_valid,
    input  logic [COMPLETE_W*IW-1:0]     cmp_idx,
    input  logic [COMPLETE_W*XLEN-1:0]   cmp_data,

    input  logic [2*TAG_W-1:0]           src_tag,
    output logic [1:0]                   src_ready,
    output logic [2*XLEN-1:0]            src_data,

    output logic [RETIRE_W-1:0]          ret_valid,
    output logic [RETIRE_W*AREG_W-1:0]   ret_areg,
    output logic [RETIRE_W*TAG_W-1:0]    ret_tag,
    output logic [RETIRE_W*XLEN-1:0]     ret_data,
    output logic [RETIRE_W*PC_W-1:0]     ret_pc,

    output logic [CW-1:0]                count,
    output logic                         full,
    output logic                         empty
);

    logic              ent_valid [ROB_DEPTH];
    logic              ent_done  [ROB_DEPTH];
    logic [PC_W-1:0]   ent_pc    [ROB_DEPTH];
    logic [AREG_W-1:0] ent_areg  [ROB_DEPTH];
    logic [TAG_W-1:0]  ent_tag   [ROB_DEPTH];
    logic [XLEN-1:0]   ent_data  [ROB_DEPTH];

    logic [IW-1:0]     head;
    logic [IW-1:0]     tail;

    logic [CW-1:0]     free_slots;
    logic [CW-1:0]     disp_num;
    logic [CW-1:0]     ret_num;
    logic [IW-1:0]     lane_idx [DISPATCH_W];
    logic [IW-1:0]     ret_ix   [RETIRE_W];
    logic [IW-1:0]     cmp_ix   [COMPLETE_W];

    // Dispatch: only the current count is used, so slots freed by a
    // same-cycle retire are not credited.
    always_comb begin
        free_slots = CW'(ROB_DEPTH) - count;
        disp_ready = !flush && (free_slots >= CW'(DISPATCH_W));
    end

    // Valid lanes are packed onto consecutive entries starting at tail.
    always_comb begin
        logic [IW-1:0] off;
        off      = '0;
        disp_num = '0;
        disp_idx = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            lane_idx[i]          = tail + off;
            disp_idx[i*IW +: IW] = tail + off;
            if (disp_valid[i]) begin
                off      = off + IW'(1);
                disp_num = disp_num + CW'(1);
            end
        end
        if (!disp_ready) begin
            disp_num = '0;
        end
    end

    always_comb begin
        for (int p = 0; p < COMPLETE_W; p++) begin
            cmp_ix[p] = cmp_idx[p*IW +: IW];
        end
    end

    // Retire: an in-order prefix of valid, done entries starting at head.
    always_comb begin
        logic go;
        go        = !rst && !flush;
        ret_num   = '0;
        ret_valid = '0;
        ret_areg  = '0;
        ret_tag   = '0;
        ret_data  = '0;
        ret_pc    = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            ret_ix[k] = head + IW'(k);
            go = go && ent_valid[ret_ix[k]] && ent_done[ret_ix[k]];
            ret_valid[k]                   = go;
            ret_areg[k*AREG_W +: AREG_W]   = ent_areg[ret_ix[k]];
            ret_tag[k*TAG_W +: TAG_W]      = ent_tag[ret_ix[k]];
            ret_data[k*XLEN +: XLEN]       = ent_data[ret_ix[k]];
            ret_pc[k*PC_W +: PC_W]         = ent_pc[ret_ix[k]];
            if (go) begin
                ret_num = ret_num + CW'(1);
            end
        end
    end

    // Lookup: tags are unique among live entries, so at most one stored hit.
    // The bypass ports are scanned afterwards so they override stored state,
    // and the highest-numbered matching port wins.
    always_comb begin
        src_ready = '0;
        src_data  = '0;
        for (int s = 0; s < 2; s++) begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                if (ent_valid[e] && ent_done[e] &&
                    ent_tag[e] == src_tag[s*TAG_W +: TAG_W]) begin
                    src_ready[s]              = 1'b1;
                    src_data[s*XLEN +: XLEN]  = ent_data[e];
                end
            end
`ifdef ROB_CMP_BYPASS_EN
            for (int p = 0; p < COMPLETE_W; p++) begin
                if (cmp_valid[p] && ent_valid[cmp_ix[p]] &&
                    ent_tag[cmp_ix[p]] == src_tag[s*TAG_W +: TAG_W]) begin
                    src_ready[s]              = 1'b1;
                    src_data[s*XLEN +: XLEN]  = cmp_data[p*XLEN +: XLEN];
                end
            end
`endif
        end
        if (rst) begin
            src_ready = '0;
            src_data  = '0;
        end
    end

    always_comb begin
        full  = (count == CW'(ROB_DEPTH));
        empty = (count == '0);
    end

    // Ordering inside the else branch matters: completions first (later
    // ports overwrite earlier ones), then retire clears, then allocation.
    // Allocated entries are never live, so they cannot collide with retires.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                ent_valid[e] <= 1'b0;
                ent_done[e]  <= 1'b0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int p = 0; p < COMPLETE_W; p++) begin
                if (cmp_valid[p] && ent_valid[cmp_ix[p]]) begin
                    ent_done[cmp_ix[p]] <= 1'b1;
                    ent_data[cmp_ix[p]] <= cmp_data[p*XLEN +: XLEN];
                end
            end
            for (int k = 0; k < RETIRE_W; k++) begin
                if (ret_valid[k]) begin
                    ent_valid[ret_ix[k]] <= 1'b0;
                    ent_done[ret_ix[k]]  <= 1'b0;
                end
            end
            if (disp_ready) begin
                for (int i = 0; i < DISPATCH_W; i++) begin
                    if (disp_valid[i]) begin
                        ent_valid[lane_idx[i]] <= 1'b1;
                        ent_done[lane_idx[i]]  <= 1'b0;
                        ent_data[lane_idx[i]]  <= '0;
                        ent_pc[lane_idx[i]]    <= disp_pc[i*PC_W +: PC_W];
                        ent_areg[lane_idx[i]]  <= disp_areg[i*AREG_W +: AREG_W];
                        ent_tag[lane_idx[i]]   <= disp_tag[i*TAG_W +: TAG_W];
                    end
                end
            end
            head  <= head + ret_num[IW-1:0];
            tail  <= tail + disp_num[IW-1:0];
            count <= count + disp_num - ret_num;
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
// ---------------------------------------------------------------------------
// tb_rob_multiport
//   Self-checking bench for rob_multiport. A queue of live entries in program
//   order serves as the reference; outputs are compared every cycle on the
//   falling edge, with directed scenarios followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_rob_multiport;

    localparam int D   = 64;
    localparam int DW  = 2;
    localparam int CPW = 3;
    localparam int RW  = 2;
    localparam int XL  = 32;
    localparam int AW  = 5;
    localparam int TW  = 6;
    localparam int PW  = 32;
    localparam int IW  = 6;
    localparam int CW  = 7;

    logic               clk;
    logic               rst;
    logic               flush;
    logic [DW-1:0]      disp_valid;
    logic [DW*PW-1:0]   disp_pc;
    logic [DW*AW-1:0]   disp_areg;
    logic [DW*TW-1:0]   disp_tag;
    logic               disp_ready;
    logic [DW*IW-1:0]   disp_idx;
    logic [CPW-1:0]     cmp_valid;
    logic [CPW*IW-1:0]  cmp_idx;
    logic [CPW*XL-1:0]  cmp_data;
    logic [2*TW-1:0]    src_tag;
    logic [1:0]         src_ready;
    logic [2*XL-1:0]    src_data;
    logic [RW-1:0]      ret_valid;
    logic [RW*AW-1:0]   ret_areg;
    logic [RW*TW-1:0]   ret_tag;
    logic [RW*XL-1:0]   ret_data;
    logic [RW*PW-1:0]   ret_pc;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;

    rob_multiport dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_pc(disp_pc), .disp_areg(disp_areg),
        .disp_tag(disp_tag), .disp_ready(disp_ready), .disp_idx(disp_idx),
        .cmp_valid(cmp_valid), .cmp_idx(cmp_idx), .cmp_data(cmp_data),
        .src_tag(src_tag), .src_ready(src_ready), .src_data(src_data),
        .ret_valid(ret_valid), .ret_areg(ret_areg), .ret_tag(ret_tag),
        .ret_data(ret_data), .ret_pc(ret_pc),
        .count(count), .full(full), .empty(empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          idx;
        bit          done;
        logic [31:0] pc;
        logic [4:0]  areg;
        logic [5:0]  tag;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   m_head;
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        else
            n_pass++;
    endtask

    function automatic bit tag_live(input logic [5:0] t);
        foreach (q[j]) if (q[j].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [5:0] free_tag(input logic [5:0] avoid, input bit use_avoid);
        int start;
        logic [5:0] t;
        start = $urandom_range(0, 63);
        for (int i = 0; i < 64; i++) begin
            t = 6'((start + i) % 64);
            if (!tag_live(t) && !(use_avoid && t == avoid)) return t;
        end
        return 6'(start);
    endfunction

    task automatic clear_inputs();
        flush = 0; disp_valid = '0; disp_pc = '0; disp_areg = '0; disp_tag = '0;
        cmp_valid = '0; cmp_idx = '0; cmp_data = '0; src_tag = '0;
    endtask

    task automatic set_disp(input int lane, input logic [5:0] tag, input logic [4:0] areg, input logic [31:0] pc);
        disp_valid[lane]        = 1'b1;
        disp_tag[lane*TW +: TW] = tag;
        disp_areg[lane*AW +: AW] = areg;
        disp_pc[lane*PW +: PW]  = pc;
    endtask

    task automatic set_cmp(input int port, input int idx, input logic [31:0] data);
        cmp_valid[port]           = 1'b1;
        cmp_idx[port*IW +: IW]    = IW'(idx);
        cmp_data[port*XL +: XL]   = data;
    endtask

    // Expected outputs from the queue model and the inputs currently applied.
    task automatic check_outputs();
        int sz, tail, off;
        bit lane_ok, exp_v, r;
        logic [31:0] d;
        logic [5:0] t;
        sz   = q.size();
        tail = (m_head + sz) % D;
        if (!rst) begin
            check("disp_ready", 64'(disp_ready), 64'(!flush && (D - sz >= DW)));
            off = 0;
            for (int i = 0; i < DW; i++) begin
                check($sformatf("disp_idx%0d", i), 64'(disp_idx[i*IW +: IW]), 64'((tail + off) % D));
                if (disp_valid[i]) off++;
            end
            check("count", 64'(count), 64'(sz));
            check("full", 64'(full), 64'(sz == D));
            check("empty", 64'(empty), 64'(sz == 0));
        end
        lane_ok = !rst && !flush;
        for (int k = 0; k < RW; k++) begin
            exp_v = 1'b0;
            if (lane_ok && k < sz) exp_v = q[k].done;
            lane_ok = exp_v;
            check($sformatf("ret_valid%0d", k), 64'(ret_valid[k]), 64'(exp_v));
            if (exp_v) begin
                check($sformatf("ret_data%0d", k), 64'(ret_data[k*XL +: XL]), 64'(q[k].data));
                check($sformatf("ret_tag%0d", k), 64'(ret_tag[k*TW +: TW]), 64'(q[k].tag));
                check($sformatf("ret_areg%0d", k), 64'(ret_areg[k*AW +: AW]), 64'(q[k].areg));
                check($sformatf("ret_pc%0d", k), 64'(ret_pc[k*PW +: PW]), 64'(q[k].pc));
            end
        end
        for (int s = 0; s < 2; s++) begin
            t = src_tag[s*TW +: TW];
            r = 1'b0;
            d = '0;
            foreach (q[j]) if (q[j].tag == t && q[j].done) begin r = 1'b1; d = q[j].data; end
`ifdef ROB_CMP_BYPASS_EN
            for (int p = 0; p < CPW; p++)
                if (cmp_valid[p])
                    foreach (q[j])
                        if (q[j].idx == int'(cmp_idx[p*IW +: IW]) && q[j].tag == t) begin
                            r = 1'b1; d = cmp_data[p*XL +: XL];
                        end
`endif
            if (rst) begin r = 1'b0; d = '0; end
            check($sformatf("src_ready%0d", s), 64'(src_ready[s]), 64'(r));
            check($sformatf("src_data%0d", s), 64'(src_data[s*XL +: XL]), 64'(d));
        end
    endtask

    task automatic update_model();
        int sz, tail, nret, off;
        ent_t e;
        if (rst || flush) begin
            q.delete();
            m_head = 0;
            return;
        end
        sz   = q.size();
        tail = (m_head + sz) % D;
        nret = 0;
        for (int k = 0; k < RW; k++)
            if (k < sz && nret == k && q[k].done) nret++;
        for (int p = 0; p < CPW; p++)
            if (cmp_valid[p])
                for (int j = 0; j < sz; j++)
                    if (q[j].idx == int'(cmp_idx[p*IW +: IW])) begin
                        e = q[j]; e.done = 1'b1; e.data = cmp_data[p*XL +: XL]; q[j] = e;
                    end
        for (int k = 0; k < nret; k++) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % D;
        end
        if (D - sz >= DW) begin
            off = 0;
            for (int i = 0; i < DW; i++)
                if (disp_valid[i]) begin
                    e.idx  = (tail + off) % D;
                    e.done = 1'b0;
                    e.data = '0;
                    e.pc   = disp_pc[i*PW +: PW];
                    e.areg = disp_areg[i*AW +: AW];
                    e.tag  = disp_tag[i*TW +: TW];
                    q.push_back(e);
                    off++;
                end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic rand_inputs(input int disp_pct, input int flush_pct);
        logic [5:0] t0, t1;
        clear_inputs();
        t0 = free_tag(6'd0, 1'b0);
        t1 = free_tag(t0, 1'b1);
        set_disp(0, t0, 5'($urandom), $urandom);
        set_disp(1, t1, 5'($urandom), $urandom);
        disp_valid[0] = ($urandom_range(0, 99) < disp_pct);
        disp_valid[1] = ($urandom_range(0, 99) < disp_pct);
        for (int p = 0; p < CPW; p++)
            if ($urandom_range(0, 99) < 60) begin
                if (q.size() > 0 && $urandom_range(0, 4) != 0)
                    set_cmp(p, q[$urandom_range(0, q.size() - 1)].idx, $urandom);
                else
                    set_cmp(p, $urandom_range(0, D - 1), $urandom);
            end
        if (cmp_valid[0] && $urandom_range(0, 7) == 0)
            set_cmp(2, int'(cmp_idx[0 +: IW]), $urandom);
        for (int s = 0; s < 2; s++)
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                src_tag[s*TW +: TW] = q[$urandom_range(0, q.size() - 1)].tag;
            else
                src_tag[s*TW +: TW] = 6'($urandom);
        flush = ($urandom_range(0, 99) < flush_pct);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_head  = 0;
        clear_inputs();
        rst = 1'b1;
        disp_valid = 2'b11;
        @(posedge clk);
        update_model();
        #1;
        #2;
        check("rst_ret_valid", 64'(ret_valid), 64'd0);
        check("rst_src_ready", 64'(src_ready), 64'd0);
        check("rst_src_data", 64'(src_data), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_disp_ready", 64'(disp_ready), 64'd1);
        check("rst_disp_idx", 64'(disp_idx), 64'h040);
        check("rst_count", 64'(count), 64'd0);
        tick();
        rst = 1'b0;
        clear_inputs();

        // Two-lane dispatch, then out-of-order completion and a paired retire.
        set_disp(0, 6'd5, 5'd1, 32'h100);
        set_disp(1, 6'd6, 5'd2, 32'h104);
        src_tag[0 +: TW] = 6'd5;
        #3;
        check("tp1_disp_idx", 64'(disp_idx), 64'h040);
        tick();
        check("tp1_count", 64'(count), 64'd2);
        clear_inputs();
        src_tag[0 +: TW] = 6'd5;
        #3;
        check("tp1_src_ready", 64'(src_ready[0]), 64'd0);
        set_cmp(0, 1, 32'hBEEF);
        tick();
        clear_inputs();
        #3;
        check("tp2_no_retire", 64'(ret_valid), 64'd0);
        set_cmp(0, 0, 32'h1234);
        tick();
        clear_inputs();
        #3;
        check("tp2_ret_valid", 64'(ret_valid), 64'd3);
        check("tp2_ret_data", 64'(ret_data), 64'h0000BEEF_00001234);
        tick();
        check("tp2_empty", 64'(empty), 64'd1);

        // Fill to 63 entries; a dispatch while not ready is dropped.
        for (int c = 0; c < 31; c++) begin
            clear_inputs();
            set_disp(0, 6'(2 * c), 5'(c), 32'(c * 8));
            set_disp(1, 6'(2 * c + 1), 5'(c), 32'(c * 8 + 4));
            tick();
        end
        clear_inputs();
        set_disp(0, 6'd62, 5'd3, 32'h200);
        tick();
        clear_inputs();
        set_disp(0, 6'd63, 5'd3, 32'h300);
        set_disp(1, 6'd63, 5'd3, 32'h304);
        #3;
        check("fill_disp_ready", 64'(disp_ready), 64'd0);
        tick();
        check("fill_dropped_count", 64'(count), 64'd63);
        clear_inputs();
        set_cmp(1, 2, 32'hCAFE);
        tick();
        clear_inputs();
        #3;
        check("fill_ret_one", 64'(ret_valid), 64'd1);
        check("fill_ready_still_0", 64'(disp_ready), 64'd0);
        tick();
        clear_inputs();
        #3;
        check("fill_count62", 64'(count), 64'd62);
        check("fill_ready_back", 64'(disp_ready), 64'd1);
        flush = 1'b1;
        tick();

        // Flush with live and done entries plus same-cycle dispatch/complete.
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            set_disp(0, 6'(10 + 2 * c), 5'(c), 32'h400 + 32'(c * 8));
            set_disp(1, 6'(11 + 2 * c), 5'(c), 32'h404 + 32'(c * 8));
            tick();
        end
        clear_inputs();
        set_cmp(0, 3, 32'h33);
        set_cmp(1, 5, 32'h55);
        tick();
        clear_inputs();
        set_disp(0, 6'd20, 5'd7, 32'h500);
        set_disp(1, 6'd21, 5'd7, 32'h504);
        set_cmp(0, 4, 32'h44);
        flush = 1'b1;
        #3;
        check("flush_ret_valid", 64'(ret_valid), 64'd0);
        check("flush_disp_ready", 64'(disp_ready), 64'd0);
        tick();
        check("flush_count", 64'(count), 64'd0);
        clear_inputs();
        src_tag = {6'd20, 6'd13};
        #3;
        check("flush_lookup", 64'(src_ready), 64'd0);
        tick();

        // Walk head and tail to 63, then wrap a two-lane dispatch.
        for (int c = 0; c < 63; c++) begin
            clear_inputs();
            set_disp(0, 6'd1, 5'd9, 32'(c));
            tick();
            clear_inputs();
            set_cmp(0, c, 32'(c + 1));
            tick();
            clear_inputs();
            tick();
        end
        clear_inputs();
        set_disp(0, 6'd30, 5'd4, 32'h600);
        set_disp(1, 6'd31, 5'd5, 32'h604);
        #3;
        check("wrap_disp_idx", 64'(disp_idx), 64'h03F);
        tick();
        clear_inputs();
        set_cmp(0, 63, 32'hA);
        set_cmp(1, 0, 32'hB);
        tick();
        clear_inputs();
        #3;
        check("wrap_ret_valid", 64'(ret_valid), 64'd3);
        tick();
        clear_inputs();
        #3;
        check("wrap_head", 64'(disp_idx[0 +: IW]), 64'd1);

        // Same-cycle lookup of a completing entry.
        set_disp(0, 6'd9, 5'd9, 32'h700);
        tick();
        clear_inputs();
        set_cmp(2, 1, 32'h55);
        src_tag[0 +: TW] = 6'd9;
        #3;
`ifdef ROB_CMP_BYPASS_EN
        check("byp_same_ready", 64'(src_ready[0]), 64'd1);
        check("byp_same_data", 64'(src_data[0 +: XL]), 64'h55);
`else
        check("byp_same_ready", 64'(src_ready[0]), 64'd0);
        check("byp_same_data", 64'(src_data[0 +: XL]), 64'h0);
`endif
        tick();
        clear_inputs();
        src_tag[0 +: TW] = 6'd9;
        #3;
        check("byp_next_ready", 64'(src_ready[0]), 64'd1);
        check("byp_next_data", 64'(src_data[0 +: XL]), 64'h55);
        tick();

        // Randomized traffic with alternating occupancy pressure.
        for (int it = 0; it < 3000; it++) begin
            rand_inputs(((it / 300) % 2 == 0) ? 85 : 30, 2);
            if (it == 1500) rst = 1'b1;
            tick();
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rob_multiport.md
# rob_multiport

Parametrised reorder buffer for the out-of-order core: allocates up to DISPATCH_W entries per cycle in program order, and accepts up to COMPLETE_W out-of-order completions. It retires up to RETIRE_W consecutive completed entries per cycle to the architectural register file. It also answers source-operand readiness and data lookups by physical tag at dispatch, and supports a single-cycle pipeline flush.

## Interface
- ROB_DEPTH, 64: entries; power of two, at least 4 and at least DISPATCH_W.
- DISPATCH_W, 2: allocation lanes per cycle.
- COMPLETE_W, 3: completion ports.
- RETIRE_W, 2: retire lanes per cycle.
- XLEN, 32: data width. AREG_W, 5: architectural register index width. TAG_W, 6: physical tag width. PC_W, 32: PC width.
- IW = $clog2(ROB_DEPTH); CW = IW+1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all entries.
- disp_valid  in  DISPATCH_W  per-lane allocate request.
- disp_pc  in  DISPATCH_W*PC_W  instruction PC, packed with lane 0 in the LSBs.
- disp_areg  in  DISPATCH_W*AREG_W  destination architectural register.
- disp_tag  in  DISPATCH_W*TAG_W  destination physical tag.
- disp_ready  out  1  all lanes can be accepted this cycle.
- disp_idx  out  DISPATCH_W*IW  entry index assigned to each lane.
- cmp_valid  in  COMPLETE_W  completion strobe.
- cmp_idx  in  COMPLETE_W*IW  entry being completed.
- cmp_data  in  COMPLETE_W*XLEN  result.
- src_tag  in  2*TAG_W  tags to look up.
- src_ready  out  2  tag is held by a live, completed entry.
- src_data  out  2*XLEN  its data, 0 if not ready.
- ret_valid  out  RETIRE_W  lane retires this cycle.
- ret_areg / ret_tag / ret_data / ret_pc  out  RETIRE_W*(AREG_W / TAG_W / XLEN / PC_W)  retiring entry fields.
- count  out  CW  live entries. full / empty  out  1  count==ROB_DEPTH / count==0.

## Operation
- State: per entry valid, done, pc, areg, tag, data; plus head, tail (IW bits, wrapping modulo ROB_DEPTH) and count.
- Dispatch:
  - disp_ready = !flush && (ROB_DEPTH - count) >= DISPATCH_W.
  - Lane i maps to tail + (number of valid lanes below i). disp_idx reports this value even when the lane is not valid.
  - On accept, each allocated entry is set valid=1, done=0, data=0. Tail advances by popcount(disp_valid).
  - Dispatch while disp_ready=0 is dropped.
- Completion:
  - A strobe sets done=1 and writes data at cmp_idx, but only if that entry is valid. Completions to invalid entries are ignored.
  - Two ports targeting the same index: the higher port number wins.
- Retire:
  - Lane k is valid iff lanes 0..k-1 are valid and the entry at head+k is valid and done.
  - Outputs are combinational from registered state. At the edge, retired entries are cleared and head advances by the retire count.
  - Retirement stops at the first entry that is not done.
- Count update: count_next = count + dispatched - retired.
- Lookup: match src_tag against all valid entries. Tags are unique among live entries, so there is at most one hit. src_ready = hit && done.
- Flush:
  - Clears every valid bit and sets head=tail=count=0.
  - Takes priority over dispatch, completion and retire in the same cycle.
  - ret_valid is forced to 0 while flush is high.
- Reset state: all entries invalid, head=tail=count=0.
  - Output values in reset: ret_valid=0, src_ready=0, src_data=0, empty=1, full=0, disp_ready=1, disp_idx lanes = 0,1,...
- Reset mid-operation discards everything; no retire is emitted that cycle.

## Timing
- Dispatch accepted at edge N: completion to that index is legal from cycle N+1.
- Completion at edge N: retire and lookup see it in cycle N+1 (same cycle with the bypass below).
- disp_ready uses only current count; entries freed by a retire in the same cycle are not credited.
- Wrap-around: tail at ROB_DEPTH-1 with two lanes allocates indices ROB_DEPTH-1 and 0.

## Configuration
- ROB_CMP_BYPASS_EN defined: lookup also matches same-cycle completion ports.
  - The completing entry's tag is read at cmp_idx and compared against src_tag.
  - On a match, src_ready=1 and src_data=cmp_data, with priority over stored entries and the highest port winning.
- ROB_CMP_BYPASS_EN undefined: lookup uses registered state only; a completion becomes visible one cycle later.

## Test plan
- Reset then dispatch 2 lanes with tags 5 and 6 -> disp_idx = 0 and 1; count=2 next cycle; src_ready=0 for tag 5.
- Complete idx 1 (data 0xBEEF), then idx 0 (data 0x1234) a cycle later -> no retire after the first; the cycle after the second, ret_valid=2'b11 with data 0x1234 then 0xBEEF; empty=1 afterwards.
- Fill to count=63 -> disp_ready=0 and dispatch is dropped. Retire one entry -> count=62 and disp_ready returns the following cycle.
- Wrap: head=tail=63, dispatch 2 -> indices 63 and 0; completing and retiring both leaves head=1.
- Flush with 10 live entries, some done, plus a same-cycle dispatch and completion -> count=0, ret_valid=0, the dispatch is discarded, and a later lookup of those tags gives src_ready=0.
- With ROB_CMP_BYPASS_EN, complete the tag-9 entry with 0x55 while src_tag=9 -> src_ready=1 and src_data=0x55 in the same cycle. Without it, the same result appears one cycle later.
